ped_button_conditioner: RTL and testbench

- Upstream stage of the pedestrian traffic-light controller.
- Turns the raw, bouncy, asynchronous, active-low pedestrian push-button into a clean, synchronous, latched crossing request.
- Request is held until the light controller acknowledges it. Also flags a stuck button and counts accepted presses for board diagnostics.

---
 rtl/ped_button_conditioner.sv | 125 ++++++++++++
 tb/tb_ped_button_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button front end: synchronizes and debounces the raw active-low
// button, latches a crossing request until acknowledged, flags a stuck button and counts presses.
module ped_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STUCK_CYCLES    = 60000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       req_ack,
  output logic       req,
  output logic       btn_clean,
  output logic       btn_press,
  output logic       stuck,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_MAX  = CNT_W'(STUCK_CYCLES);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_btn_clean;
  logic             r_btn_press;
  logic [CNT_W-1:0] r_stuck_cnt;
  logic             r_stuck;
  logic [7:0]       r_press_count;

  logic w_pressed_s;
  logic w_differs;
  logic w_db_done;
  logic w_press_evt;
  logic w_release_evt;

  assign w_pressed_s   = ~r_sync2;
  assign w_differs     = (w_pressed_s != r_btn_clean);
  assign w_db_done     = w_differs && (r_db_cnt == DB_LAST);
  assign w_press_evt   = w_db_done && w_pressed_s;
  assign w_release_evt = w_db_done && !w_pressed_s;

  // Sync flops reset to the released level so a button held through reset still counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_cnt    <= '0;
      r_btn_clean <= 1'b0;
      r_btn_press <= 1'b0;
    end else begin
      r_btn_press <= w_press_evt;
      if (!w_differs) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_btn_clean <= w_pressed_s;
        r_db_cnt    <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  // Stuck clears on the same edge the debounced level falls, not one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else if (!r_btn_clean || w_release_evt) begin
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else if (r_stuck_cnt != STUCK_MAX) begin
      r_stuck_cnt <= r_stuck_cnt + CNT_W'(1);
      if (r_stuck_cnt == STUCK_LAST) begin
        r_stuck <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_press_count <= 8'd0;
    end else if (w_press_evt && (r_press_count != 8'hFF)) begin
      r_press_count <= r_press_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The request moves on the press event itself so req rises together with btn_press.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_press_evt) w_state_next = PENDING;
      PENDING: if (req_ack && !w_press_evt) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign req         = (r_state == PENDING);
  assign btn_clean   = r_btn_clean;
  assign btn_press   = r_btn_press;
  assign stuck       = r_stuck;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Self-checking bench for ped_button_conditioner: directed scenarios with literal
// expectations plus randomized button/ack/reset traffic against a behavioural model.
module tb_ped_button_conditioner;

  localparam int D = 4;
  localparam int S = 20;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       req_ack;
  logic       req;
  logic       btn_clean;
  logic       btn_press;
  logic       stuck;
  logic [7:0] press_count;

  int checks;
  int failures;

  ped_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STUCK_CYCLES(S),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .req_ack(req_ack),
    .req(req),
    .btn_clean(btn_clean),
    .btn_press(btn_press),
    .stuck(stuck),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the button level seen two edges late; the clean level flips
  // once the seen level has disagreed with it for D consecutive edges.
  bit m_s1, m_s2, m_clean, m_press, m_pend, m_stuck, m_ps, m_flip;
  int m_run, m_cnt, m_k, m_rise;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_s1 = 1; m_s2 = 1; m_clean = 0; m_press = 0; m_pend = 0; m_stuck = 0;
        m_run = 0; m_cnt = 0; m_k = 0; m_rise = 0;
      end else begin
        m_k++;
        m_ps = !m_s2;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        if (m_ps == m_clean) m_run = 0;
        else m_run++;
        m_flip  = (m_run == D);
        m_press = m_flip && m_ps;
        if (m_flip) begin
          m_clean = m_ps;
          m_run   = 0;
          if (m_ps) m_rise = m_k;
        end
        if (m_press) begin
          m_pend = 1;
          if (m_cnt < 255) m_cnt++;
        end else if (req_ack) begin
          m_pend = 0;
        end
        m_stuck = m_clean && ((m_k - m_rise) >= S);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_req",       32'(req),         32'(m_pend));
      check("cmp_btn_clean", 32'(btn_clean),   32'(m_clean));
      check("cmp_btn_press", 32'(btn_press),   32'(m_press));
      check("cmp_stuck",     32'(stuck),       32'(m_stuck));
      check("cmp_count",     32'(press_count), m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch_press(input int n, output int pulses, output int idx);
    pulses = 0;
    idx    = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (btn_press) begin
        pulses++;
        idx = i;
      end
    end
  endtask

  int pulses, idx, hold;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; btn_raw = 1'b1; req_ack = 1'b0;
    tick(3);
    check("rst_req", 32'(req), 0);
    check("rst_clean", 32'(btn_clean), 0);
    check("rst_press", 32'(btn_press), 0);
    check("rst_stuck", 32'(stuck), 0);
    check("rst_count", 32'(press_count), 0);
    rst = 1'b1;
    tick(3);

    // Clean press
    btn_raw = 1'b0;
    tick(5);
    check("press_clean_e5", 32'(btn_clean), 0);
    tick(1);
    check("press_clean_e6", 32'(btn_clean), 1);
    check("press_pulse_e6", 32'(btn_press), 1);
    check("press_req_e6", 32'(req), 1);
    check("press_count_e6", 32'(press_count), 1);
    check("model_press_e6", 32'(m_press), 1);
    check("model_pend_e6", 32'(m_pend), 1);
    tick(1);
    check("press_pulse_e7", 32'(btn_press), 0);
    tick(3);
    btn_raw = 1'b1;
    tick(8);
    check("release_clean", 32'(btn_clean), 0);
    check("release_req", 32'(req), 1);
    check("release_count", 32'(press_count), 1);

    // Handshake
    req_ack = 1'b1; tick(1); req_ack = 1'b0;
    check("ack_req", 32'(req), 0);
    btn_raw = 1'b0; tick(6);
    check("p2_req", 32'(req), 1);
    check("p2_count", 32'(press_count), 2);
    btn_raw = 1'b1; tick(8);
    btn_raw = 1'b0; tick(5);
    req_ack = 1'b1; tick(1); req_ack = 1'b0;
    check("p3_press", 32'(btn_press), 1);
    check("p3_req_ack_same", 32'(req), 1);
    check("p3_count", 32'(press_count), 3);
    tick(1);
    check("p3_req_hold", 32'(req), 1);
    btn_raw = 1'b1; tick(8);
    req_ack = 1'b1; tick(1); req_ack = 1'b0;
    check("p3_req_clear", 32'(req), 0);

    // Bounce
    btn_raw = 1'b0; tick(2); btn_raw = 1'b1; tick(2);
    btn_raw = 1'b0; tick(2); btn_raw = 1'b1; tick(2);
    btn_raw = 1'b0;
    watch_press(12, pulses, idx);
    check("bounce_pulses", pulses, 1);
    check("bounce_edge", idx, 6);
    check("bounce_count", 32'(press_count), 4);
    btn_raw = 1'b1; tick(10);

    // Stuck
    btn_raw = 1'b0;
    tick(25);
    check("stuck_e25", 32'(stuck), 0);
    tick(1);
    check("stuck_e26", 32'(stuck), 1);
    check("stuck_count", 32'(press_count), 5);
    tick(14);
    btn_raw = 1'b1;
    tick(5);
    check("stuck_before_fall", 32'(stuck), 1);
    tick(1);
    check("stuck_fall_clean", 32'(btn_clean), 0);
    check("stuck_fall", 32'(stuck), 0);
    tick(2);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      btn_raw = 1'b0; tick(7);
      btn_raw = 1'b1; tick(7);
    end
    check("sat_count", 32'(press_count), 255);
    check("sat_req", 32'(req), 1);

    // Reset mid-debounce with a pending request
    btn_raw = 1'b0; tick(3);
    #2 rst = 1'b0;
    #1;
    check("arst_req", 32'(req), 0);
    check("arst_clean", 32'(btn_clean), 0);
    check("arst_press", 32'(btn_press), 0);
    check("arst_stuck", 32'(stuck), 0);
    check("arst_count", 32'(press_count), 0);
    btn_raw = 1'b1;
    tick(2);
    rst = 1'b1;
    watch_press(12, pulses, idx);
    check("arst_no_press", pulses, 0);

    // Button held through reset release
    btn_raw = 1'b0; rst = 1'b0; tick(2); rst = 1'b1;
    watch_press(12, pulses, idx);
    check("held_pulses", pulses, 1);
    check("held_edge", idx, 6);
    check("held_count", 32'(press_count), 1);
    btn_raw = 1'b1; tick(10);

    // Randomized traffic
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 6));
      end
      hold--;
      req_ack = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst = 1'b1; req_ack = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
